// File: rtl/satd_block_ctrl.sv
// Block sequencer for the row-parallel SATD datapath: fetches ROWS operand rows,
// streams them out, then sums per-row costs. Define SATD_CTRL_SAT_EN for a saturating accumulator.
module satd_block_ctrl #(
  parameter int ROWS  = 8,
  parameter int RES_W = 16,
  parameter int ACC_W = 20,
  localparam int AW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] satd,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [63:0]      rd_org,
  input  logic [63:0]      rd_cur,
  output logic             dp_valid,
  output logic [63:0]      dp_org,
  output logic [63:0]      dp_cur,
  input  logic             dp_res_valid,
  input  logic [RES_W-1:0] dp_res
);

  localparam int CW = $clog2(ROWS + 1);
  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_RES = CW'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    row_cnt;
  logic [CW-1:0]    res_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] satd_q;
  logic             vld_p1;
  logic             accept;
  logic             collect;
  logic             last_res;

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [RES_W-1:0] b);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + (ACC_W + 1)'(b);
`ifdef SATD_CTRL_SAT_EN
    return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    return sum[ACC_W-1:0];
`endif
  endfunction

  assign accept   = (state_q == S_IDLE) && start && !abort;
  assign collect  = ((state_q == S_FETCH) || (state_q == S_DRAIN)) && dp_res_valid;
  assign last_res = collect && (res_cnt == LAST_RES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_FETCH;
      S_FETCH: begin
        if (abort)                    state_d = S_IDLE;
        else if (last_res)            state_d = S_DONE;
        else if (row_cnt == LAST_ROW) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)         state_d = S_IDLE;
        else if (last_res) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // An abort in DONE suppresses the pulse and the result update in the same cycle.
  always_comb begin
    busy    = (state_q != S_IDLE);
    rd_en   = (state_q == S_FETCH);
    rd_addr = row_cnt;
    done    = (state_q == S_DONE) && !abort;
    satd    = done ? acc : satd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt <= '0;
      res_cnt <= '0;
      acc     <= '0;
      satd_q  <= '0;
    end else begin
      if (accept) begin
        row_cnt <= '0;
        res_cnt <= '0;
        acc     <= '0;
      end else begin
        if ((state_q == S_FETCH) && (row_cnt != LAST_ROW)) row_cnt <= row_cnt + AW'(1);
        if (collect) begin
          res_cnt <= res_cnt + CW'(1);
          acc     <= acc_add(acc, dp_res);
        end
      end
      if (done) satd_q <= acc;
    end
  end

  // p1: buffer data is valid this cycle; p2: registered row presented to the datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      dp_valid <= 1'b0;
      dp_org   <= '0;
      dp_cur   <= '0;
    end else begin
      vld_p1   <= rd_en && !abort;
      dp_valid <= vld_p1 && !abort;
      if (vld_p1) begin
        dp_org <= rd_org;
        dp_cur <= rd_cur;
      end
    end
  end

endmodule

// File: doc/satd_block_ctrl.md
# satd_block_ctrl

Sequencer for the row-parallel SATD datapath (8 pixels × 8 bits per operand row, `ORG`/`CUR`). On `start` it fetches the rows of one block from the block buffer and streams them into the datapath. It then collects one partial cost per row and accumulates them into a block SATD. It reports the result with a done pulse. It sits between the motion-estimation search control and the `SATD` datapath instance.

## Interface
Parameters:
- `ROWS`, 8, rows per block (2..8); `AW = $clog2(ROWS)`, minimum 1
- `RES_W`, 16, width of the per-row datapath result (unsigned)
- `ACC_W`, 20, width of the block accumulator / `satd` output

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: request one block; accepted only in IDLE
- `abort` in 1: cancel the current block
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse, result valid
- `satd` out ACC_W: last completed block cost, held until the next `done`
- `rd_en` out 1: block-buffer read strobe
- `rd_addr` out AW: row index
- `rd_org`, `rd_cur` in 64: buffer data, valid exactly 1 cycle after `rd_en`
- `dp_valid` out 1: row presented to the datapath
- `dp_org`, `dp_cur` out 64: registered row operands
- `dp_res_valid` in 1: datapath per-row result strobe
- `dp_res` in RES_W: per-row result

## Operation
- States:
  - IDLE: `busy`=0.
  - FETCH: issues `ROWS` reads.
  - DRAIN: waits for outstanding results.
  - DONE: 1 cycle, `done`=1.
- IDLE→FETCH on `start`=1 with `abort`=0. On that edge: row counter ← 0, result counter ← 0, accumulator ← 0.
- FETCH:
  - `rd_en`=1 every cycle, `rd_addr` = row counter, incrementing.
  - Leaves for DRAIN in the cycle after the read with `rd_addr`=ROWS-1.
- Operand pipeline:
  - `dp_valid` is `rd_en` delayed by 2 cycles.
  - `dp_org`/`dp_cur` capture `rd_org`/`rd_cur` in the cycle after `rd_en`.
  - No gaps: exactly `ROWS` consecutive `dp_valid` cycles per block.
- Result collection, in FETCH or DRAIN:
  - Each `dp_res_valid`: accumulator += zero-extended `dp_res`; result counter +1.
  - When the counter reaches `ROWS`, go to DONE on the next edge.
- DONE: `satd` ← accumulator, `done`=1, then return to IDLE.
- Ignored inputs:
  - `dp_res_valid` in IDLE or DONE.
  - `start` while `busy`=1.
- `abort`=1 in FETCH, DRAIN or DONE:
  - Next state IDLE; `rd_en` and the `dp_valid` pipeline flush to 0.
  - No `done` pulse; `satd` keeps its previous value.
  - `abort` beats `start` when both are high in IDLE.
- Arithmetic: unsigned `ACC_W`-bit adder; overflow handling is set by the configuration macro.

## Timing
- Reset values: state IDLE; `busy`, `done`, `rd_en`, `dp_valid` = 0; `rd_addr`, `dp_org`, `dp_cur`, `satd` = 0; all counters and the accumulator = 0.
- `start` sampled high at edge T:
  - `busy`=1 and `rd_en`=1 (`rd_addr`=0) from T+1.
  - Last read at T+ROWS.
  - `dp_valid` from T+3 to T+ROWS+2.
- `done` and the updated `satd` appear on the edge after the ROWS-th `dp_res_valid`.
  - With a datapath latency of L cycles from `dp_valid` to `dp_res_valid`, `done` is at T+ROWS+L+3.
- Back-to-back blocks: `start` is accepted the cycle after DONE. Minimum block period is ROWS+L+4 cycles.
- Reset asserted mid-block returns all outputs to their reset values immediately (asynchronous). No `done` follows.

## Configuration
- `SATD_CTRL_SAT_EN` defined: the accumulator saturates at 2^ACC_W−1 and stays there for the rest of the block.
- Not defined: the accumulator wraps modulo 2^ACC_W.
- All other behaviour is identical in both builds.

## Test plan
- Nominal block: ROWS=8, datapath model with L=3 returning 100 per row, `start` at T → `rd_addr` 0..7 on T+1..T+8; `done` at T+14; `satd`=800.
- Data path: buffer row i holds `ORG`=64'h0011223344556677+i, `CUR`=~`ORG` → each `dp_valid` cycle shows exactly that pair in row order.
- Overflow: ACC_W=18, every `dp_res`=16'hFFFF → `satd`=262143 with `SATD_CTRL_SAT_EN`; 262136 without it.
- Abort: `abort` during DRAIN after 5 results → IDLE next cycle, no `done`, `satd` holds 800 from the previous block. A new `start` then gives `satd`=800 again.
- Edge conditions:
  - `start` while busy → ignored, no extra reads.
  - `start`+`abort` together in IDLE → stays IDLE.
  - Stray `dp_res_valid` in IDLE → `satd` unchanged.
- Async reset: `rst` pulsed mid-FETCH between clock edges → `rd_en`, `busy` = 0 before the next edge; `satd`=0; no `done`.
